// File: rtl/cpu_stack_writeback.sv
// Stage-5 write side of the operand stack.
// Accepts a retiring stage-4 op (pop count plus up to four result words) and
// drives the stack with one pop strobe and then one push word per cycle.
// Also tracks the committed stack depth and keeps a sticky debug error flag.
// Optional feature: define CPU_WB_POP_PUSH_MERGE_EN to issue the pop and the
// first push word in the same cycle (the stack pops before it pushes).
//
// state | meaning
// ------+----------------------------------------------------------------
// IDLE  | no strobe this cycle; a new op can be accepted
// POP   | st__to_pop_5a carries the op's pop count this cycle
// PUSH  | st__to_push_5a carries word rem_q-1 of the buffered op
module cpu_stack_writeback #(
  parameter int WIDTH = 35,
  parameter int DEPTH = 2048
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       valid_4a,
  input  logic                       kill_4a,
  input  logic [2:0]                 c__to_push_4a,
  input  logic [$clog2(DEPTH)-1:0]   st__to_pop_4a,
  input  logic [4*WIDTH-1:0]         st__data_4a,
  output logic                       wb__ready_4a,
  output logic                       st__push_5a,
  output logic [WIDTH-1:0]           st__to_push_5a,
  output logic [$clog2(DEPTH)-1:0]   st__to_pop_5a,
  output logic [$clog2(DEPTH):0]     wb__depth,
  output logic                       wb__err
);

  localparam int PW = $clog2(DEPTH);
  localparam int DW = PW + 1;
  localparam logic [DW-1:0] DEPTH_MAX = DW'(DEPTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    POP  = 2'd1,
    PUSH = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [2:0]        rem_q, rem_d;
  logic [WIDTH-1:0]  buf_q [4];
  logic [WIDTH-1:0]  buf_d [4];
  logic              push_q, push_d;
  logic [WIDTH-1:0]  to_push_q, to_push_d;
  logic [PW-1:0]     to_pop_q, to_pop_d;
  logic [DW-1:0]     depth_q, depth_d;
  logic              err_q, err_d;

  logic [WIDTH-1:0]  data_w [4];
  logic [2:0]        n_in;
  logic              illegal_n;
  logic              ready_c;
  logic              accept;
  logic [DW-1:0]     depth_after_pop;
  logic              pop_err;
  logic              push_err;

  // Unpack incoming words, clamp the push count, decide whether this cycle accepts.
  always_comb begin
    for (int k = 0; k < 4; k++) begin
      data_w[k] = st__data_4a[k*WIDTH +: WIDTH];
    end
    illegal_n = (c__to_push_4a > 3'd4);
    n_in      = illegal_n ? 3'd4 : c__to_push_4a;
    ready_c   = (state_q == IDLE) ||
                ((state_q == POP)  && (rem_q == 3'd0)) ||
                ((state_q == PUSH) && (rem_q == 3'd1));
    accept    = valid_4a && !kill_4a && ready_c;
  end

  // Next-state and next-output selection: continue the current op, or start a new one.
  always_comb begin
    state_d   = IDLE;
    rem_d     = rem_q;
    push_d    = 1'b0;
    to_push_d = '0;
    to_pop_d  = '0;
    for (int k = 0; k < 4; k++) begin
      buf_d[k] = buf_q[k];
    end

    if ((state_q == POP) && (rem_q != 3'd0)) begin
      state_d   = PUSH;
      push_d    = 1'b1;
      to_push_d = buf_q[rem_q[1:0] - 2'd1];
    end else if ((state_q == PUSH) && (rem_q > 3'd1)) begin
      state_d   = PUSH;
      rem_d     = rem_q - 3'd1;
      push_d    = 1'b1;
      // rem_q 2..4 selects word 0..2; the 2-bit wrap maps rem_q=4 to index 2.
      to_push_d = buf_q[rem_q[1:0] - 2'd2];
    end else if (accept) begin
      for (int k = 0; k < 4; k++) begin
        buf_d[k] = data_w[k];
      end
      rem_d = n_in;
      if (st__to_pop_4a != '0) begin
        to_pop_d = st__to_pop_4a;
`ifdef CPU_WB_POP_PUSH_MERGE_EN
        if (n_in != 3'd0) begin
          state_d   = PUSH;
          push_d    = 1'b1;
          to_push_d = data_w[n_in[1:0] - 2'd1];
        end else begin
          state_d = POP;
        end
`else
        state_d = POP;
`endif
      end else if (n_in != 3'd0) begin
        state_d   = PUSH;
        push_d    = 1'b1;
        to_push_d = data_w[n_in[1:0] - 2'd1];
      end else begin
        rem_d = 3'd0;
      end
    end else begin
      rem_d = 3'd0;
    end
  end

  // Commit depth from the strobes presented this cycle: pop first, then push.
  always_comb begin
    pop_err  = ({1'b0, to_pop_q} > depth_q);
    depth_after_pop = pop_err ? '0 : (depth_q - {1'b0, to_pop_q});
    push_err = 1'b0;
    depth_d  = depth_after_pop;
    if (push_q) begin
      if (depth_after_pop == DEPTH_MAX) begin
        push_err = 1'b1;
      end else begin
        depth_d = depth_after_pop + 1'b1;
      end
    end
    err_d = err_q || pop_err || push_err || (accept && illegal_n);
  end

  // State, buffer and registered outputs; reset drops any op in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      rem_q     <= '0;
      push_q    <= 1'b0;
      to_push_q <= '0;
      to_pop_q  <= '0;
      depth_q   <= '0;
      err_q     <= 1'b0;
      for (int k = 0; k < 4; k++) begin
        buf_q[k] <= '0;
      end
    end else begin
      state_q   <= state_d;
      rem_q     <= rem_d;
      push_q    <= push_d;
      to_push_q <= to_push_d;
      to_pop_q  <= to_pop_d;
      depth_q   <= depth_d;
      err_q     <= err_d;
      for (int k = 0; k < 4; k++) begin
        buf_q[k] <= buf_d[k];
      end
    end
  end

  assign wb__ready_4a   = ready_c;
  assign st__push_5a    = push_q;
  assign st__to_push_5a = to_push_q;
  assign st__to_pop_5a  = to_pop_q;
  assign wb__depth      = depth_q;
  assign wb__err        = err_q;

endmodule

// File: tb/tb_cpu_stack_writeback.sv
// Directed bench for cpu_stack_writeback; expected values are hand-computed.
// Build with +define+CPU_WB_POP_PUSH_MERGE_EN to exercise the merged pop/push.
module tb_cpu_stack_writeback;

  logic          clk = 1'b0;
  logic          rst;
  logic          valid_4a;
  logic          kill_4a;
  logic [2:0]    c__to_push_4a;
  logic [10:0]   st__to_pop_4a;
  logic [139:0]  st__data_4a;
  logic          wb__ready_4a;
  logic          st__push_5a;
  logic [34:0]   st__to_push_5a;
  logic [10:0]   st__to_pop_5a;
  logic [11:0]   wb__depth;
  logic          wb__err;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  cpu_stack_writeback dut (
    .clk            (clk),
    .rst            (rst),
    .valid_4a       (valid_4a),
    .kill_4a        (kill_4a),
    .c__to_push_4a  (c__to_push_4a),
    .st__to_pop_4a  (st__to_pop_4a),
    .st__data_4a    (st__data_4a),
    .wb__ready_4a   (wb__ready_4a),
    .st__push_5a    (st__push_5a),
    .st__to_push_5a (st__to_push_5a),
    .st__to_pop_5a  (st__to_pop_5a),
    .wb__depth      (wb__depth),
    .wb__err        (wb__err)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [139:0] pack4(input logic [34:0] w0, input logic [34:0] w1,
                                         input logic [34:0] w2, input logic [34:0] w3);
    return {w3, w2, w1, w0};
  endfunction

  task automatic op(input logic [10:0] pop, input logic [2:0] n, input logic [139:0] d);
    valid_4a      = 1'b1;
    kill_4a       = 1'b0;
    st__to_pop_4a = pop;
    c__to_push_4a = n;
    st__data_4a   = d;
  endtask

  task automatic nop();
    valid_4a      = 1'b0;
    kill_4a       = 1'b0;
    st__to_pop_4a = '0;
    c__to_push_4a = '0;
    st__data_4a   = '0;
  endtask

  logic [34:0] w [4];

  initial begin
    rst = 1'b1;
    nop();
    tick();
    tick();
    check("rst_push",   st__push_5a,    1'b0);
    check("rst_topush", st__to_push_5a, 35'd0);
    check("rst_pop",    st__to_pop_5a,  11'd0);
    check("rst_depth",  wb__depth,      12'd0);
    check("rst_err",    wb__err,        1'b0);
    check("rst_ready",  wb__ready_4a,   1'b1);
    rst = 1'b0;
    tick();

    // pop=0, N=3, words A,B,C -> pushes C,B,A
    op(11'd0, 3'd3, pack4(35'h4_0000_000A, 35'h2_0000_000B, 35'h1_0000_000C, 35'h7_FFFF_FFFF));
    #1 check("n3_ready_t", wb__ready_4a, 1'b1);
    tick(); nop();
    check("n3_push1", st__push_5a, 1'b1);
    check("n3_word1", st__to_push_5a, 35'h1_0000_000C);
    check("n3_rdy1",  wb__ready_4a, 1'b0);
    tick();
    check("n3_word2", st__to_push_5a, 35'h2_0000_000B);
    check("n3_rdy2",  wb__ready_4a, 1'b0);
    tick();
    check("n3_word3", st__to_push_5a, 35'h4_0000_000A);
    check("n3_push3", st__push_5a, 1'b1);
    check("n3_rdy3",  wb__ready_4a, 1'b1);
    tick();
    check("n3_idle",  st__push_5a, 1'b0);
    check("n3_depth", wb__depth, 12'd3);

    // pop=2, N=1 at depth 3
    op(11'd2, 3'd1, pack4(35'h5_1234_5678, 35'd0, 35'd0, 35'd0));
    tick(); nop();
`ifdef CPU_WB_POP_PUSH_MERGE_EN
    check("pp_pop1",  st__to_pop_5a, 11'd2);
    check("pp_push1", st__push_5a, 1'b1);
    check("pp_word",  st__to_push_5a, 35'h5_1234_5678);
    check("pp_rdy1",  wb__ready_4a, 1'b1);
    tick();
`else
    check("pp_pop1",  st__to_pop_5a, 11'd2);
    check("pp_push1", st__push_5a, 1'b0);
    check("pp_rdy1",  wb__ready_4a, 1'b0);
    tick();
    check("pp_pop2",  st__to_pop_5a, 11'd0);
    check("pp_push2", st__push_5a, 1'b1);
    check("pp_word",  st__to_push_5a, 35'h5_1234_5678);
    check("pp_rdy2",  wb__ready_4a, 1'b1);
    tick();
`endif
    check("pp_done",  st__push_5a, 1'b0);
    check("pp_pop0",  st__to_pop_5a, 11'd0);
    check("pp_depth", wb__depth, 12'd2);
    check("pp_err",   wb__err, 1'b0);

    // four back-to-back 1-word pushes
    w[0] = 35'h0_0000_0011; w[1] = 35'h0_0000_0022;
    w[2] = 35'h3_0000_0033; w[3] = 35'h6_0000_0044;
    for (int i = 0; i < 4; i++) begin
      op(11'd0, 3'd1, pack4(w[i], 35'h7_0000_0000, 35'd0, 35'd0));
      #1 check($sformatf("b2b_rdy%0d", i), wb__ready_4a, 1'b1);
      tick();
      check($sformatf("b2b_push%0d", i), st__push_5a, 1'b1);
      check($sformatf("b2b_word%0d", i), st__to_push_5a, w[i]);
    end
    nop();
    tick();
    check("b2b_idle",  st__push_5a, 1'b0);
    check("b2b_depth", wb__depth, 12'd6);

    // killed op
    op(11'd5, 3'd2, pack4(35'h1, 35'h2, 35'd0, 35'd0));
    kill_4a = 1'b1;
    #1 check("kill_rdy", wb__ready_4a, 1'b1);
    tick();
    check("kill_push", st__push_5a, 1'b0);
    check("kill_pop",  st__to_pop_5a, 11'd0);
    nop();
    tick();
    check("kill_depth", wb__depth, 12'd6);
    check("kill_push2", st__push_5a, 1'b0);

    // pop 5, N=0 at depth 6
    op(11'd5, 3'd0, '0);
    tick(); nop();
    check("p5_pop", st__to_pop_5a, 11'd5);
    check("p5_rdy", wb__ready_4a, 1'b1);
    tick();
    check("p5_pop0",  st__to_pop_5a, 11'd0);
    check("p5_depth", wb__depth, 12'd1);
    check("p5_err",   wb__err, 1'b0);

    // underflow: pop 3 at depth 1
    op(11'd3, 3'd0, '0);
    tick(); nop();
    check("uf_pop", st__to_pop_5a, 11'd3);
    tick();
    check("uf_pop0",  st__to_pop_5a, 11'd0);
    check("uf_depth", wb__depth, 12'd0);
    check("uf_err",   wb__err, 1'b1);

    // illegal N=7 clamps to 4
    op(11'd0, 3'd7, pack4(35'h100, 35'h101, 35'h102, 35'h103));
    tick(); nop();
    check("il_w3", st__to_push_5a, 35'h103);
    tick();
    check("il_w2", st__to_push_5a, 35'h102);
    tick();
    check("il_w1", st__to_push_5a, 35'h101);
    tick();
    check("il_w0", st__to_push_5a, 35'h100);
    check("il_rdy", wb__ready_4a, 1'b1);
    tick();
    check("il_idle",  st__push_5a, 1'b0);
    check("il_depth", wb__depth, 12'd4);
    check("il_err",   wb__err, 1'b1);

    // reset held two cycles in the middle of a 4-word push
    op(11'd0, 3'd4, pack4(35'h200, 35'h201, 35'h202, 35'h203));
    tick(); nop();
    check("mr_w3", st__to_push_5a, 35'h203);
    tick();
    check("mr_w2", st__to_push_5a, 35'h202);
    rst = 1'b1;
    tick();
    check("mr_push",  st__push_5a, 1'b0);
    check("mr_pop",   st__to_pop_5a, 11'd0);
    check("mr_depth", wb__depth, 12'd0);
    check("mr_err",   wb__err, 1'b0);
    tick();
    rst = 1'b0;
    check("mr_push2", st__push_5a, 1'b0);
    tick();
    check("mr_push3",  st__push_5a, 1'b0);
    check("mr_topush", st__to_push_5a, 35'd0);
    check("mr_depth3", wb__depth, 12'd0);
    tick();
    check("mr_push4", st__push_5a, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
